// File: rtl/drac_icache_pkg.sv
// Shared icache refill types: L2 request/response structs, refill FSM states, geometry constants.
package drac_icache_pkg;

  localparam int PADDR_SIZE         = 26;
  localparam int WAY_WIDHT          = 128;
  localparam int ICACHE_N_WAY       = 4;
  localparam int ICACHE_N_WAY_CLOG2 = 2;

  localparam int unsigned IFILL_TIMEOUT_DEFAULT = 1024;

  typedef struct packed {
    logic                          valid;
    logic [ICACHE_N_WAY_CLOG2-1:0] way;
    logic [PADDR_SIZE-1:0]         paddr;
  } ifill_req_o_t;

  typedef struct packed {
    logic                 valid;
    logic                 ack;
    logic [WAY_WIDHT-1:0] data;
    logic [1:0]           beat;
  } ifill_resp_i_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    WRITE,
    DRAIN
  } ifill_state_t;

endpackage

// File: rtl/icache_ifill_ctrl.sv
// Icache line refill controller: one outstanding L2 refill, round-robin victim way, flush handling.
// ICACHE_IFILL_TIMEOUT_EN adds a refill watchdog that aborts and pulses xcpt_o.
module icache_ifill_ctrl
  import drac_icache_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = IFILL_TIMEOUT_DEFAULT,
  parameter logic [1:0]  LAST_BEAT      = 2'd0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          miss_valid_i,
  input  logic [PADDR_SIZE-1:0]         miss_paddr_i,
  output logic                          miss_ready_o,
  input  logic                          kill_i,
  output ifill_req_o_t                  ifill_req_o,
  input  ifill_resp_i_t                 ifill_resp_i,
  output logic                          line_valid_o,
  output logic [WAY_WIDHT-1:0]          line_data_o,
  output logic [ICACHE_N_WAY_CLOG2-1:0] line_way_o,
  output logic [PADDR_SIZE-1:0]         line_paddr_o,
  output logic                          busy_o,
  output logic                          xcpt_o
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  ifill_state_t                  state, state_next;
  logic                          kill_q, kill_d;
  logic [ICACHE_N_WAY_CLOG2-1:0] rr_q, way_q;
  logic [PADDR_SIZE-1:0]         paddr_q;
  logic [WAY_WIDHT-1:0]          data_q;
  logic                          accept, last_beat, abort;

  assign miss_ready_o = (state == IDLE) && !kill_i;
  assign accept       = miss_valid_i && miss_ready_o;
  assign last_beat    = ifill_resp_i.valid && (ifill_resp_i.beat == LAST_BEAT);

`ifdef ICACHE_IFILL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;
  logic          xcpt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt <= '0;
      xcpt_q <= 1'b0;
    end else begin
      xcpt_q <= abort;
      if (accept)             to_cnt <= '0;
      else if (state != IDLE) to_cnt <= to_cnt + 1'b1;
    end
  end

  // A last beat arriving on the final cycle still counts as completion.
  assign abort  = (state == REQ || state == WAIT || state == DRAIN) && (to_cnt == TO_LAST)
                  && !(last_beat && (state == WAIT || state == DRAIN));
  assign xcpt_o = xcpt_q;
`else
  assign abort  = 1'b0;
  assign xcpt_o = 1'b0;
`endif

  always_comb begin
    state_next = state;
    kill_d     = kill_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = REQ;
          kill_d     = 1'b0;
        end
      end
      REQ: begin
        // The request stays up until acked even after a flush; the kill is remembered.
        if (kill_i) kill_d = 1'b1;
        if (ifill_resp_i.ack) state_next = (kill_q || kill_i) ? DRAIN : WAIT;
      end
      WAIT: begin
        if (last_beat)   state_next = kill_i ? IDLE : WRITE;
        else if (kill_i) state_next = DRAIN;
      end
      WRITE: state_next = IDLE;
      DRAIN: if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      kill_q  <= 1'b0;
      rr_q    <= '0;
      way_q   <= '0;
      paddr_q <= '0;
      data_q  <= '0;
    end else begin
      state  <= state_next;
      kill_q <= kill_d;
      if (accept) begin
        way_q   <= rr_q;
        paddr_q <= miss_paddr_i;
      end
      if (state_next == WRITE) data_q <= ifill_resp_i.data;
      if (state == WRITE)      rr_q   <= rr_q + 1'b1;
    end
  end

  assign ifill_req_o  = '{valid: (state == REQ), way: way_q, paddr: paddr_q};
  assign line_valid_o = (state == WRITE);
  assign line_data_o  = data_q;
  assign line_way_o   = way_q;
  assign line_paddr_o = paddr_q;
  assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_icache_ifill_ctrl.sv
// Directed bench for icache_ifill_ctrl; the timeout scenario follows ICACHE_IFILL_TIMEOUT_EN.
module tb_icache_ifill_ctrl;
  import drac_icache_pkg::*;

  logic                          clk_i = 1'b0;
  logic                          rst_i;
  logic                          miss_valid_i;
  logic [PADDR_SIZE-1:0]         miss_paddr_i;
  logic                          miss_ready_o;
  logic                          kill_i;
  ifill_req_o_t                  ifill_req_o;
  ifill_resp_i_t                 ifill_resp_i;
  logic                          line_valid_o;
  logic [WAY_WIDHT-1:0]          line_data_o;
  logic [ICACHE_N_WAY_CLOG2-1:0] line_way_o;
  logic [PADDR_SIZE-1:0]         line_paddr_o;
  logic                          busy_o;
  logic                          xcpt_o;

  int errors = 0;
  int checks = 0;

  logic                          obs_valid;
  logic [ICACHE_N_WAY_CLOG2-1:0] obs_way;
  logic [PADDR_SIZE-1:0]         obs_paddr;
  logic [WAY_WIDHT-1:0]          obs_data;

  icache_ifill_ctrl #(.TIMEOUT_CYCLES(16), .LAST_BEAT(2'd0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .miss_valid_i(miss_valid_i), .miss_paddr_i(miss_paddr_i), .miss_ready_o(miss_ready_o),
    .kill_i(kill_i), .ifill_req_o(ifill_req_o), .ifill_resp_i(ifill_resp_i),
    .line_valid_o(line_valid_o), .line_data_o(line_data_o), .line_way_o(line_way_o),
    .line_paddr_o(line_paddr_o), .busy_o(busy_o), .xcpt_o(xcpt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    miss_valid_i = 1'b0;
    miss_paddr_i = '0;
    kill_i       = 1'b0;
    ifill_resp_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // Full refill: accept, ack one cycle later, one ignored non-last beat, then the last beat.
  task automatic run_refill(input logic [PADDR_SIZE-1:0] pa, input logic [WAY_WIDHT-1:0] d);
    miss_valid_i = 1'b1; miss_paddr_i = pa;
    tick();
    miss_valid_i = 1'b0; ifill_resp_i.ack = 1'b1;
    tick();
    ifill_resp_i.ack = 1'b0;
    ifill_resp_i.valid = 1'b1; ifill_resp_i.beat = 2'd1; ifill_resp_i.data = ~d;
    tick();
    ifill_resp_i.beat = 2'd0; ifill_resp_i.data = d;
    tick();
    obs_valid = line_valid_o; obs_way = line_way_o; obs_paddr = line_paddr_o; obs_data = line_data_o;
    ifill_resp_i = '0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (ifill_req_o !== '0) begin errors++; $display("FAIL reset_req got %h exp 0", ifill_req_o); end
    checks++; if (line_valid_o !== 1'b0 || line_way_o !== '0 || line_paddr_o !== '0 || line_data_o !== '0) begin
      errors++; $display("FAIL reset_line got v=%b w=%0d pa=%h exp all 0", line_valid_o, line_way_o, line_paddr_o); end
    checks++; if (xcpt_o !== 1'b0) begin errors++; $display("FAIL reset_xcpt got %b exp 0", xcpt_o); end
    checks++; if (miss_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", miss_ready_o); end
    kill_i = 1'b1; #1;
    checks++; if (miss_ready_o !== 1'b0) begin errors++; $display("FAIL ready_kill got %b exp 0", miss_ready_o); end
    kill_i = 1'b0;
  endtask

  task automatic test_basic();
    logic [WAY_WIDHT-1:0] d;
    d = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
    do_reset();
    miss_valid_i = 1'b1; miss_paddr_i = 26'h0001040;                       // cycle 0
    tick();
    miss_valid_i = 1'b0; miss_paddr_i = 26'h3FFFFFF;                       // cycle 1
    checks++; if (ifill_req_o.valid !== 1'b1 || ifill_req_o.paddr !== 26'h0001040 || ifill_req_o.way !== 2'd0) begin
      errors++; $display("FAIL basic_req got v=%b pa=%h w=%0d exp 1/0001040/0", ifill_req_o.valid, ifill_req_o.paddr, ifill_req_o.way); end
    checks++; if (miss_ready_o !== 1'b0) begin errors++; $display("FAIL basic_ready_busy got %b exp 0", miss_ready_o); end
    tick();
    ifill_resp_i.ack = 1'b1;                                                // cycle 2
    checks++; if (ifill_req_o.valid !== 1'b1) begin errors++; $display("FAIL basic_req_held got %b exp 1", ifill_req_o.valid); end
    tick();
    ifill_resp_i.ack = 1'b0;                                                // cycle 3
    checks++; if (ifill_req_o.valid !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL basic_wait got v=%b busy=%b exp 0/1", ifill_req_o.valid, busy_o); end
    tick(); tick();
    ifill_resp_i.valid = 1'b1; ifill_resp_i.beat = 2'd0; ifill_resp_i.data = d; // cycle 5
    checks++; if (line_valid_o !== 1'b0) begin errors++; $display("FAIL basic_early_write got %b exp 0", line_valid_o); end
    tick();
    ifill_resp_i = '0;                                                      // cycle 6
    checks++; if (line_valid_o !== 1'b1 || line_way_o !== 2'd0 || line_paddr_o !== 26'h0001040 || line_data_o !== d) begin
      errors++; $display("FAIL basic_write got v=%b w=%0d pa=%h d=%h exp 1/0/0001040/%h", line_valid_o, line_way_o, line_paddr_o, line_data_o, d); end
    checks++; if (miss_ready_o !== 1'b0) begin errors++; $display("FAIL basic_ready_write got %b exp 0", miss_ready_o); end
    tick();                                                                 // cycle 7
    checks++; if (line_valid_o !== 1'b0 || miss_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL basic_done got v=%b rdy=%b busy=%b exp 0/1/0", line_valid_o, miss_ready_o, busy_o); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_way [5];
    exp_way = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      logic [PADDR_SIZE-1:0] pa;
      logic [WAY_WIDHT-1:0] d;
      pa = 26'h0002000 + 26'(i * 64);
      d  = {4{32'h11110000 + 32'(i)}};
      run_refill(pa, d);
      checks++; if (obs_valid !== 1'b1 || obs_way !== exp_way[i] || obs_paddr !== pa || obs_data !== d) begin
        errors++; $display("FAIL b2b_%0d got v=%b w=%0d pa=%h exp 1/%0d/%h", i, obs_valid, obs_way, obs_paddr, exp_way[i], pa); end
    end
  endtask

  task automatic test_kill_req();
    do_reset();
    miss_valid_i = 1'b1; miss_paddr_i = 26'h0003000;
    tick();
    miss_valid_i = 1'b0; kill_i = 1'b1;
    checks++; if (ifill_req_o.valid !== 1'b1) begin errors++; $display("FAIL killreq_valid got %b exp 1", ifill_req_o.valid); end
    tick();
    kill_i = 1'b0;
    checks++; if (ifill_req_o.valid !== 1'b1 || ifill_req_o.paddr !== 26'h0003000) begin
      errors++; $display("FAIL killreq_held got v=%b pa=%h exp 1/0003000", ifill_req_o.valid, ifill_req_o.paddr); end
    ifill_resp_i.ack = 1'b1;
    tick();
    ifill_resp_i.ack = 1'b0;
    ifill_resp_i.valid = 1'b1; ifill_resp_i.beat = 2'd0; ifill_resp_i.data = {4{32'hBAD0BAD0}};
    checks++; if (busy_o !== 1'b1 || ifill_req_o.valid !== 1'b0) begin
      errors++; $display("FAIL killreq_drain got busy=%b v=%b exp 1/0", busy_o, ifill_req_o.valid); end
    tick();
    ifill_resp_i = '0;
    checks++; if (line_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL killreq_discard got v=%b busy=%b exp 0/0", line_valid_o, busy_o); end
    run_refill(26'h0003040, {4{32'h5A5A5A5A}});
    checks++; if (obs_valid !== 1'b1 || obs_way !== 2'd0) begin
      errors++; $display("FAIL killreq_way got v=%b w=%0d exp 1/0", obs_valid, obs_way); end
  endtask

  task automatic test_kill_wait();
    do_reset();
    miss_valid_i = 1'b1; miss_paddr_i = 26'h0004000;
    tick();
    miss_valid_i = 1'b0; ifill_resp_i.ack = 1'b1;
    tick();
    ifill_resp_i.ack = 1'b0;
    ifill_resp_i.valid = 1'b1; ifill_resp_i.beat = 2'd0; kill_i = 1'b1;
    tick();
    ifill_resp_i = '0; kill_i = 1'b0;
    checks++; if (line_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL killlast got v=%b busy=%b exp 0/0", line_valid_o, busy_o); end
    miss_valid_i = 1'b1; miss_paddr_i = 26'h0004040;
    tick();
    miss_valid_i = 1'b0; ifill_resp_i.ack = 1'b1;
    tick();
    ifill_resp_i.ack = 1'b0; kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    ifill_resp_i.valid = 1'b1; ifill_resp_i.beat = 2'd0;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL killwait_drain got busy=%b exp 1", busy_o); end
    tick();
    ifill_resp_i = '0;
    checks++; if (line_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL killwait_done got v=%b busy=%b exp 0/0", line_valid_o, busy_o); end
  endtask

  task automatic test_idle_resp();
    do_reset();
    ifill_resp_i.valid = 1'b1; ifill_resp_i.beat = 2'd0; ifill_resp_i.ack = 1'b1;
    tick();
    ifill_resp_i = '0;
    checks++; if (line_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL idle_resp got v=%b busy=%b exp 0/0", line_valid_o, busy_o); end
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    do_reset();
    miss_valid_i = 1'b1; miss_paddr_i = 26'h0005000;
    tick();                                             // first REQ cycle
    miss_valid_i = 1'b0; ifill_resp_i.ack = 1'b1;
    tick();
    ifill_resp_i.ack = 1'b0;
    for (int k = 1; k < 16; k++) begin
      if (xcpt_o !== 1'b0) early = 1'b1;
      tick();
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL timeout_early got 1 exp 0"); end
`ifdef ICACHE_IFILL_TIMEOUT_EN
    checks++; if (xcpt_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse got x=%b busy=%b exp 1/0", xcpt_o, busy_o); end
    tick();
    ifill_resp_i.valid = 1'b1; ifill_resp_i.beat = 2'd0;
    checks++; if (xcpt_o !== 1'b0) begin errors++; $display("FAIL timeout_one_cycle got %b exp 0", xcpt_o); end
    tick();
    ifill_resp_i = '0;
    checks++; if (line_valid_o !== 1'b0) begin errors++; $display("FAIL timeout_late_resp got %b exp 0", line_valid_o); end
    run_refill(26'h0005040, {4{32'h0F0F0F0F}});
    checks++; if (obs_way !== 2'd0) begin errors++; $display("FAIL timeout_way got %0d exp 0", obs_way); end
`else
    checks++; if (xcpt_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL notimeout_wait got x=%b busy=%b exp 0/1", xcpt_o, busy_o); end
    ifill_resp_i.valid = 1'b1; ifill_resp_i.beat = 2'd0;
    tick();
    ifill_resp_i = '0;
    checks++; if (line_valid_o !== 1'b1 || xcpt_o !== 1'b0) begin
      errors++; $display("FAIL notimeout_write got v=%b x=%b exp 1/0", line_valid_o, xcpt_o); end
    tick();
`endif
  endtask

  task automatic test_reset_wait();
    do_reset();
    miss_valid_i = 1'b1; miss_paddr_i = 26'h0006000;
    tick();
    miss_valid_i = 1'b0; ifill_resp_i.ack = 1'b1;
    tick();
    ifill_resp_i.ack = 1'b0; rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++; if (busy_o !== 1'b0 || ifill_req_o !== '0 || line_valid_o !== 1'b0 || line_paddr_o !== '0
                  || line_way_o !== '0 || line_data_o !== '0 || xcpt_o !== 1'b0 || miss_ready_o !== 1'b1) begin
      errors++; $display("FAIL rstwait_outputs got busy=%b req=%h v=%b pa=%h x=%b rdy=%b exp 0/0/0/0/0/1",
                         busy_o, ifill_req_o, line_valid_o, line_paddr_o, xcpt_o, miss_ready_o); end
    ifill_resp_i.valid = 1'b1; ifill_resp_i.beat = 2'd0;
    tick();
    ifill_resp_i = '0;
    checks++; if (line_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL rstwait_stray got v=%b busy=%b exp 0/0", line_valid_o, busy_o); end
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_kill_req();
    test_kill_wait();
    test_idle_resp();
    test_timeout();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
